// File: rtl/up_dn_counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
package up_dn_counter_pkg;

  // Behaviour at a limit crossing
  localparam logic MODE_SATURATE = 1'b0;
  localparam logic MODE_WRAP     = 1'b1;

  // Supported counter widths
  localparam int unsigned UDC_MIN_WIDTH = 2;
  localparam int unsigned UDC_MAX_WIDTH = 32;

endpackage

// File: rtl/param_up_dn_counter_if.sv
// Control/status bundle of param_up_dn_counter. The master side drives requests and
// limits, the slave side (the counter) returns the count and status.
interface param_up_dn_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             En;
  logic             Load;
  logic [WIDTH-1:0] IN;
  logic             Up;
  logic             Down;
  logic [WIDTH-1:0] Step;
  logic [WIDTH-1:0] Min;
  logic [WIDTH-1:0] Max;
  logic             Wrap_Mode;
  logic             Clr_Flags;
  logic [WIDTH-1:0] Counter;
  logic             High;
  logic             Low;
  logic             Wrap;
  logic             Ovf;
  logic             Unf;
  logic             Cfg_Err;

  modport master (
    output En, Load, IN, Up, Down, Step, Min, Max, Wrap_Mode, Clr_Flags,
    input  Counter, High, Low, Wrap, Ovf, Unf, Cfg_Err
  );

  modport slave (
    input  En, Load, IN, Up, Down, Step, Min, Max, Wrap_Mode, Clr_Flags,
    output Counter, High, Low, Wrap, Ovf, Unf, Cfg_Err
  );
endinterface

// File: rtl/up_dn_next_value.sv
// Combinational next-count calculation for one up or down step, including limit
// crossing detection and the saturate/wrap resolution.
module up_dn_next_value
  import up_dn_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  input  logic             up,
  input  logic             mode,
  output logic [WIDTH-1:0] next_val,
  output logic             ovf,
  output logic             unf,
  output logic             wrap
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] room;
  logic           below;

  // Extra bit keeps the carry of counter + step; room is only meaningful when counter >= min
  always_comb begin
    sum   = {1'b0, counter} + {1'b0, step};
    room  = {1'b0, counter} - {1'b0, min};
    below = (counter < min) || ({1'b0, step} > room);
  end

  // Resolve the step against the limits; a zero step is always a hold
  always_comb begin
    next_val = counter;
    ovf      = 1'b0;
    unf      = 1'b0;
    wrap     = 1'b0;
    if (step != '0) begin
      if (up) begin
        if (sum > {1'b0, max}) begin
          ovf = 1'b1;
          if (mode == MODE_WRAP) begin
            next_val = min;
            wrap     = 1'b1;
          end else begin
            next_val = max;
          end
        end else begin
          next_val = sum[WIDTH-1:0];
        end
      end else begin
        if (below) begin
          unf = 1'b1;
          if (mode == MODE_WRAP) begin
            next_val = max;
            wrap     = 1'b1;
          end else begin
            next_val = min;
          end
        end else begin
          next_val = counter - step;
        end
      end
    end
  end

endmodule

// File: rtl/param_up_dn_counter.sv
// Parametrised up/down counter with runtime limits, saturate/wrap mode, wrap pulse and
// overflow/underflow flags. Define PARAM_UP_DN_COUNTER_STICKY_EN to make Ovf/Unf sticky
// until Clr_Flags or reset; otherwise they are one-cycle event pulses.
module param_up_dn_counter
  import up_dn_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                 CLK,
  input logic                 RST,
  param_up_dn_counter_if.slave bus
);

  if (WIDTH < UDC_MIN_WIDTH || WIDTH > UDC_MAX_WIDTH) begin : g_width_check
    $error("param_up_dn_counter: WIDTH out of supported range");
  end

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             cfg_err;
  logic             count_req;
  logic             ovf_ev, unf_ev;
  logic [WIDTH-1:0] nv_val;
  logic             nv_ovf, nv_unf, nv_wrap;

  up_dn_next_value #(
    .WIDTH(WIDTH)
  ) u_next (
    .counter (counter_q),
    .step    (bus.Step),
    .min     (bus.Min),
    .max     (bus.Max),
    .up      (bus.Up),
    .mode    (bus.Wrap_Mode),
    .next_val(nv_val),
    .ovf     (nv_ovf),
    .unf     (nv_unf),
    .wrap    (nv_wrap)
  );

  // Configuration check and single-direction count request
  always_comb begin
    cfg_err   = bus.Min > bus.Max;
    count_req = bus.En & (bus.Up ^ bus.Down);
  end

  // Priority: load, then inconsistent-limit hold, then counting
  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    ovf_ev    = 1'b0;
    unf_ev    = 1'b0;
    if (bus.Load) begin
      if (cfg_err) begin
        counter_d = bus.IN;
      end else if (bus.IN < bus.Min) begin
        counter_d = bus.Min;
      end else if (bus.IN > bus.Max) begin
        counter_d = bus.Max;
      end else begin
        counter_d = bus.IN;
      end
    end else if (!cfg_err && count_req) begin
      counter_d = nv_val;
      wrap_d    = nv_wrap;
      ovf_ev    = nv_ovf;
      unf_ev    = nv_unf;
    end
  end

`ifdef PARAM_UP_DN_COUNTER_STICKY_EN
  // Sticky flags: a new event on the clearing edge wins over the clear
  always_comb begin
    ovf_d = ovf_ev | (ovf_q & ~bus.Clr_Flags);
    unf_d = unf_ev | (unf_q & ~bus.Clr_Flags);
  end
`else
  logic unused_clr_flags;
  assign unused_clr_flags = bus.Clr_Flags;

  // Pulse flags: high only on the cycle after the event edge
  always_comb begin
    ovf_d = ovf_ev;
    unf_d = unf_ev;
  end
`endif

  // Count and status registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      counter_q <= RST_VAL;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.Counter = counter_q;
  assign bus.High    = counter_q == bus.Max;
  assign bus.Low     = counter_q == bus.Min;
  assign bus.Wrap    = wrap_q;
  assign bus.Ovf     = ovf_q;
  assign bus.Unf     = unf_q;
  assign bus.Cfg_Err = cfg_err;

endmodule

// File: doc/param_up_dn_counter.md
# param_up_dn_counter

Parametrised up/down counter: the next generation of the team's fixed 5-bit up/down counter. Adds configurable width and step, runtime min/max limits, a saturate-or-wrap mode, a count enable, asynchronous reset, a one-cycle wrap pulse and optional sticky overflow/underflow flags. Used as a general event, position or credit counter wherever the fixed 5-bit block is too narrow or too rigid.

## Interface
- `WIDTH`, 8: counter width in bits, 2..32.
- `RST_VAL`, 0: value of `Counter` after reset, WIDTH bits.
- `CLK` input 1: sole clock; all state updates on the rising edge.
- `RST` input 1: asynchronous reset, active-high.
- `En` input 1: count enable; gates `Up` and `Down` only.
- `Load` input 1: synchronous load of `IN`.
- `IN` input WIDTH: load value.
- `Up` input 1: count-up request.
- `Down` input 1: count-down request.
- `Step` input WIDTH: increment/decrement magnitude; 0 means hold.
- `Min` input WIDTH: lower limit, unsigned.
- `Max` input WIDTH: upper limit, unsigned.
- `Wrap_Mode` input 1: 0 = saturate at limits, 1 = wrap to the opposite limit.
- `Clr_Flags` input 1: synchronous clear of the sticky flags.
- `Counter` output WIDTH: current count, registered.
- `High` output 1: `Counter == Max`, combinational.
- `Low` output 1: `Counter == Min`, combinational.
- `Wrap` output 1: one-cycle pulse, registered.
- `Ovf` output 1: sticky overflow, registered.
- `Unf` output 1: sticky underflow, registered.
- `Cfg_Err` output 1: `Min > Max`, combinational.

## Operation
- All arithmetic is unsigned and uses WIDTH+1 bits, so `Counter + Step` never loses its carry and `Counter - Step` is evaluated as "`Step > Counter - Min`".
- Priority per edge: `Load` first, then `Cfg_Err` hold, then counting.
- Load:
  - `Counter <= IN`, clamped into [Min, Max] (below Min gives Min, above Max gives Max).
  - Ignores `En`.
  - If `Cfg_Err`, `Counter <= IN` unclamped.
- `Cfg_Err` = 1 with no `Load`: `Counter` holds and no flag or pulse is generated.
- Counting (when `En` = 1):
  - Exactly one of `Up` or `Down` must be high. Both high, or neither high, means hold.
  - Up, when `Counter + Step <= Max`: `Counter <= Counter + Step`.
  - Up, when `Counter + Step > Max`:
    - Saturate mode: `Counter <= Max`.
    - Wrap mode: `Counter <= Min` and `Wrap` pulses.
    - In both modes, `Ovf` sets.
  - Down, when `Counter - Step >= Min`: `Counter <= Counter - Step`.
  - Down, when `Counter - Step < Min`:
    - Saturate mode: `Counter <= Min`.
    - Wrap mode: `Counter <= Max` and `Wrap` pulses.
    - In both modes, `Unf` sets.
  - Landing exactly on a limit is not an overflow or underflow.
  - Up at `Counter == Max` with `Step > 0` is an overflow, so saturate mode holds and sets `Ovf`.
- `Counter` outside [Min, Max] (after a limit change) is allowed:
  - The next count step applies the crossing rules above.
  - The value is not silently corrected without a count request.
- `Clr_Flags`: clears `Ovf` and `Unf`. If a new overflow or underflow happens on the same edge, set wins.

## Timing
- Reset values: `Counter = RST_VAL`, `Wrap = 0`, `Ovf = 0`, `Unf = 0`.
  - `High`, `Low` and `Cfg_Err` follow combinationally from `Counter`, `Min` and `Max`.
  - Reset is asserted asynchronously; release is expected to be synchronised externally.
- Latency: request to `Counter` update takes 1 cycle. `Wrap`, `Ovf` and `Unf` change on the same edge as `Counter`.
- `Wrap` is high for exactly one cycle per wrap event; back-to-back wraps give consecutive high cycles.
- Reset asserted mid-operation returns all registered outputs to reset values immediately, regardless of CLK.
- Changes to `Min`, `Max`, `Step` or `Wrap_Mode` take effect on the next edge, with no pipeline.

## Configuration
- Macro `PARAM_UP_DN_COUNTER_STICKY_EN`.
- Defined: `Ovf` and `Unf` are sticky until `Clr_Flags` or reset.
- Undefined:
  - `Ovf` and `Unf` become one-cycle pulses on the edge of the overflow or underflow event.
  - `Clr_Flags` is ignored.
  - Port list is unchanged.

## Structure
- Shared package `up_dn_counter_pkg`:
  - Mode constants `MODE_SATURATE = 1'b0`, `MODE_WRAP = 1'b1`.
  - Width limits `UDC_MIN_WIDTH = 2`, `UDC_MAX_WIDTH = 32`.
- One sub-module, `up_dn_next_value` (combinational):
  - Takes `Counter`, `Step`, `Min`, `Max`, direction and mode.
  - Returns the next value plus `ovf`, `unf` and `wrap` indications.
  - The top level holds only registers, priority logic and flags.

## Test plan
- WIDTH=8, `RST` pulsed mid-count at `Counter=37` → `Counter=RST_VAL` (0) immediately, `Ovf=Unf=Wrap=0`.
- Min=10, Max=20, Step=3, saturate, Up from 18 → `Counter=20`, `Ovf=1`, `High=1`; next Up keeps 20, `Ovf` stays 1.
- Min=10, Max=20, Step=4, wrap, Down from 12 → `Counter=20`, `Wrap=1` for one cycle, `Unf=1`; `Clr_Flags` → `Unf=0`.
- `Load=1`, IN=250, Max=200, with Up=1 → `Counter=200` (clamped, load wins); Up=Down=1, En=1 → hold.
- Min=50, Max=40 → `Cfg_Err=1`, count requests ignored; `Load` IN=45 → `Counter=45`.
- Macro undefined, saturate overflow at Max=255 → `Ovf` high for exactly one cycle, then 0 without `Clr_Flags`.
